// File: rtl/id_operand_scoreboard.sv
// ID-stage operand path: register file, MEM/WB forwarding per read port, and a
// per-register pending-write scoreboard that produces the RAW hazard and issue gate.
module id_operand_scoreboard #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG),
  parameter int unsigned NRP  = 2,
  parameter int unsigned CNTW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRP*AW-1:0]     rs_addr,
  input  logic [NRP-1:0]        rs_use,
  output logic [NRP*XLEN-1:0]   rs_data,
  output logic [NRP*2-1:0]      fwd_sel,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  stall,
  output logic                  issue_ready,
  output logic                  hazard,
  input  logic                  mem_fwd_valid,
  input  logic [AW-1:0]         mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  kill_valid,
  input  logic [AW-1:0]         kill_rd,
  output logic                  sb_err
);

  localparam int unsigned PMAX = (1 << CNTW) - 1;
  localparam logic [CNTW-1:0] PEND_MAX = CNTW'(PMAX);

  localparam logic [1:0] SEL_RF   = 2'd0;
  localparam logic [1:0] SEL_WB   = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  logic [XLEN-1:0] regs     [NREG];
  logic [CNTW-1:0] pend     [NREG];
  logic [CNTW-1:0] pend_nxt [NREG];
  logic [1:0]      dec_v    [NREG];
  logic [CNTW:0]   up_v     [NREG];
  logic [NREG-1:0] inc_v;
  logic [NREG-1:0] under;
  logic [NRP-1:0]  haz;
  logic            sat;
  logic            fire;

  // Indices beyond the implemented register count behave like x0 on reads
  function automatic logic in_range(input logic [AW-1:0] idx);
    return 32'(idx) < NREG;
  endfunction

  // Per-port operand selection and RAW hazard
  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [AW-1:0]   rs;
    logic            valid_rs;
    logic            mem_hit;
    logic            wb_hit;
    logic [CNTW-1:0] pend_rs;
    logic [XLEN-1:0] data;
    logic [1:0]      sel;

    assign rs       = rs_addr[p*AW +: AW];
    assign valid_rs = (rs != '0) && in_range(rs);
    assign mem_hit  = mem_fwd_valid && (mem_rd == rs);
    assign wb_hit   = wb_valid && (wb_rd == rs);
    assign pend_rs  = valid_rs ? pend[rs] : '0;

    always_comb begin
      data = '0;
      sel  = SEL_ZERO;
      if (!valid_rs) begin
        data = '0;
        sel  = SEL_ZERO;
      end else if (mem_hit) begin
        data = mem_data;
        sel  = SEL_MEM;
      end else if (wb_hit) begin
        data = wb_data;
        sel  = SEL_WB;
      end else begin
        data = regs[rs];
        sel  = SEL_RF;
      end
    end

    // Writers still outstanding beyond those being forwarded this cycle
    assign haz[p] = rs_use[p] && valid_rs &&
                    (32'(pend_rs) > (32'(mem_hit) + 32'(wb_hit)));

    assign rs_data[p*XLEN +: XLEN] = data;
    assign fwd_sel[p*2 +: 2]       = sel;
  end

  assign hazard = |haz;

  assign sat = issue_wen && (issue_rd != '0) && in_range(issue_rd) &&
               (pend[issue_rd] == PEND_MAX);

  assign issue_ready = !stall && !hazard && !sat;
  assign fire        = issue_valid && issue_ready;

  // Next pending count per register; net of issue, retire and kill in one step
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc_v[r]    = 1'b0;
      dec_v[r]    = 2'd0;
      up_v[r]     = {1'b0, pend[r]};
      pend_nxt[r] = pend[r];
      under[r]    = 1'b0;
      if (r != 0) begin
        inc_v[r] = fire && issue_wen && (issue_rd == AW'(r));
        dec_v[r] = 2'(wb_valid && (wb_rd == AW'(r))) +
                   2'(kill_valid && (kill_rd == AW'(r)));
        up_v[r]  = {1'b0, pend[r]} + (CNTW+1)'(inc_v[r]);
        if ((CNTW+1)'(dec_v[r]) > up_v[r]) begin
          pend_nxt[r] = '0;
          under[r]    = 1'b1;
        end else begin
          pend_nxt[r] = CNTW'(up_v[r] - (CNTW+1)'(dec_v[r]));
        end
      end
    end
  end

  // Scoreboard state and sticky underflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= pend_nxt[r];
      end
      if (|under) begin
        sb_err <= 1'b1;
      end
    end
  end

  // Architectural register file; entry 0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wb_valid && (wb_rd == AW'(r))) begin
          regs[r] <= wb_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Bench for id_operand_scoreboard: behavioural register/pending model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_id_operand_scoreboard;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRP  = 2;
  localparam int unsigned CNTW = 2;
  localparam int          MAXP = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NRP*AW-1:0]    rs_addr;
  logic [NRP-1:0]       rs_use;
  logic [NRP*XLEN-1:0]  rs_data;
  logic [NRP*2-1:0]     fwd_sel;
  logic                 issue_valid, issue_wen, stall;
  logic [AW-1:0]        issue_rd;
  logic                 issue_ready, hazard;
  logic                 mem_fwd_valid;
  logic [AW-1:0]        mem_rd;
  logic [XLEN-1:0]      mem_data;
  logic                 wb_valid;
  logic [AW-1:0]        wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 kill_valid;
  logic [AW-1:0]        kill_rd;
  logic                 sb_err;

  int checks = 0;
  int passes = 0;

  logic [XLEN-1:0] m_reg  [NREG];
  int              m_pend [NREG];
  bit              m_err;

  id_operand_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rs_use(rs_use), .rs_data(rs_data), .fwd_sel(fwd_sel),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .stall(stall), .issue_ready(issue_ready), .hazard(hazard),
    .mem_fwd_valid(mem_fwd_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .kill_valid(kill_valid), .kill_rd(kill_rd), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passes++;
  endtask

  // Operand a port must see, derived from the architectural rules
  function automatic void m_read(input int p, output logic [31:0] d,
                                 output logic [1:0] s, output bit hz);
    logic [AW-1:0] rs;
    bit mh, wh;
    rs = rs_addr[p*AW +: AW];
    mh = mem_fwd_valid && (mem_rd == rs);
    wh = wb_valid && (wb_rd == rs);
    if (rs == 0)      begin d = '0;       s = 2'd3; end
    else if (mh)      begin d = mem_data; s = 2'd2; end
    else if (wh)      begin d = wb_data;  s = 2'd1; end
    else              begin d = m_reg[rs]; s = 2'd0; end
    hz = rs_use[p] && (rs != 0) && (m_pend[rs] > (int'(mh) + int'(wh)));
  endfunction

  function automatic bit m_ready();
    logic [31:0] d;
    logic [1:0] s;
    bit hz, any, sat;
    any = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      m_read(p, d, s, hz);
      any = any | hz;
    end
    sat = issue_wen && (issue_rd != 0) && (m_pend[issue_rd] == MAXP);
    return !stall && !any && !sat;
  endfunction

  // Model state update
  always @(posedge clk or negedge rst) begin
    bit fire;
    int nv;
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin m_reg[r] = '0; m_pend[r] = 0; end
      m_err = 1'b0;
    end else begin
      fire = issue_valid && m_ready();
      for (int r = 1; r < NREG; r++) begin
        nv = m_pend[r];
        if (fire && issue_wen && issue_rd == AW'(r)) nv++;
        if (wb_valid && wb_rd == AW'(r)) nv--;
        if (kill_valid && kill_rd == AW'(r)) nv--;
        if (nv < 0) begin nv = 0; m_err = 1'b1; end
        m_pend[r] = nv;
      end
      if (wb_valid && wb_rd != 0) m_reg[wb_rd] = wb_data;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [31:0] d;
    logic [1:0] s;
    bit hz, any;
    any = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      m_read(p, d, s, hz);
      any = any | hz;
      chk($sformatf("rs_data%0d", p), 64'(rs_data[p*XLEN +: XLEN]), 64'(d));
      chk($sformatf("fwd_sel%0d", p), 64'(fwd_sel[p*2 +: 2]), 64'(s));
    end
    chk("hazard", 64'(hazard), 64'(any));
    chk("issue_ready", 64'(issue_ready), 64'(m_ready()));
    chk("sb_err", 64'(sb_err), 64'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = rd;
  endtask

  task automatic no_issue();
    issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0;
  endtask

  initial begin
    logic [AW-1:0] r;
    rs_addr = '0; rs_use = '0; stall = 1'b0; no_issue();
    mem_fwd_valid = 1'b0; mem_rd = '0; mem_data = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    kill_valid = 1'b0; kill_rd = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", 64'(issue_ready), 64'd1);
    chk("rst_hazard", 64'(hazard), 64'd0);
    chk("rst_sb_err", 64'(sb_err), 64'd0);
    step(); step();
    rst = 1'b1;

    // Reset then read
    rs_addr = {5'd5, 5'd0}; rs_use = 2'b11;
    #1;
    chk("rd_data", 64'(rs_data), 64'd0);
    chk("rd_sel", 64'(fwd_sel), 64'h3);
    chk("rd_hazard", 64'(hazard), 64'd0);
    chk("rd_ready", 64'(issue_ready), 64'd1);
    step();

    // RAW stall until WB
    rs_use = 2'b00; issue(5'd5);
    #1 chk("raw_issue_ready", 64'(issue_ready), 64'd1);
    step();
    no_issue(); rs_addr = {5'd0, 5'd5}; rs_use = 2'b01;
    #1;
    chk("raw_hazard", 64'(hazard), 64'd1);
    chk("raw_ready", 64'(issue_ready), 64'd0);
    step();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    chk("raw_wb_data", 64'(rs_data[31:0]), 64'hDEADBEEF);
    chk("raw_wb_sel", 64'(fwd_sel[1:0]), 64'd1);
    chk("raw_wb_hazard", 64'(hazard), 64'd0);
    step();
    wb_valid = 1'b0;
    #1;
    chk("raw_rf_data", 64'(rs_data[31:0]), 64'hDEADBEEF);
    chk("raw_rf_sel", 64'(fwd_sel[1:0]), 64'd0);
    chk("model_pend5", 64'(m_pend[5]), 64'd0);
    step();

    // MEM over WB priority
    rs_use = 2'b00; issue(5'd7);
    step(); step();
    no_issue();
    rs_addr = {5'd0, 5'd7}; rs_use = 2'b01;
    mem_fwd_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h11;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h22;
    #1;
    chk("model_pend7", 64'(m_pend[7]), 64'd2);
    chk("mem_data", 64'(rs_data[31:0]), 64'h11);
    chk("mem_sel", 64'(fwd_sel[1:0]), 64'd2);
    chk("mem_hazard", 64'(hazard), 64'd0);
    step();
    mem_fwd_valid = 1'b0; wb_valid = 1'b0;
    #1;
    chk("mem_left_hazard", 64'(hazard), 64'd1);
    chk("mem_left_data", 64'(rs_data[31:0]), 64'h22);
    step();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h33;
    #1;
    chk("mem_last_hazard", 64'(hazard), 64'd0);
    chk("mem_last_data", 64'(rs_data[31:0]), 64'h33);
    step();
    wb_valid = 1'b0;

    // Kill and double decrement
    rs_use = 2'b00; issue(5'd3);
    step(); step();
    no_issue();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h5;
    kill_valid = 1'b1; kill_rd = 5'd3;
    step();
    wb_valid = 1'b0;
    #1;
    chk("kill_sb_err0", 64'(sb_err), 64'd0);
    chk("model_pend3", 64'(m_pend[3]), 64'd0);
    step();
    kill_valid = 1'b0;
    #1 chk("kill_sb_err1", 64'(sb_err), 64'd1);

    // Saturation
    issue(5'd9);
    step(); step(); step();
    #1 chk("sat_ready", 64'(issue_ready), 64'd0);
    step();
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h9;
    #1 chk("sat_wb_ready", 64'(issue_ready), 64'd0);
    step();
    wb_valid = 1'b0;
    #1 chk("sat_release", 64'(issue_ready), 64'd1);
    step();
    no_issue();
    wb_valid = 1'b1; wb_rd = 5'd9;
    step(); step(); step();
    wb_valid = 1'b0;

    // Stall and x0
    stall = 1'b1; issue(5'd4);
    #1 chk("stall_ready", 64'(issue_ready), 64'd0);
    step();
    stall = 1'b0; no_issue();
    rs_addr = {5'd0, 5'd4}; rs_use = 2'b01;
    #1;
    chk("model_pend4", 64'(m_pend[4]), 64'd0);
    chk("stall_hazard", 64'(hazard), 64'd0);
    step();
    issue(5'd0);
    #1 chk("x0_issue_ready", 64'(issue_ready), 64'd1);
    step();
    no_issue();
    rs_addr = {5'd0, 5'd0}; rs_use = 2'b11;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    #1;
    chk("x0_data", 64'(rs_data), 64'd0);
    chk("x0_sel", 64'(fwd_sel), 64'hF);
    step();
    wb_valid = 1'b0;

    // Mixed traffic on a small register window
    for (int i = 0; i < 300; i++) begin
      rs_addr       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rs_use        = 2'($urandom_range(0, 3));
      issue_valid   = ($urandom_range(0, 1) == 1);
      issue_wen     = ($urandom_range(0, 3) != 0);
      issue_rd      = 5'($urandom_range(0, 7));
      stall         = ($urandom_range(0, 3) == 0);
      mem_fwd_valid = ($urandom_range(0, 2) == 0);
      mem_rd        = 5'($urandom_range(0, 7));
      mem_data      = $urandom;
      r             = 5'($urandom_range(1, 7));
      wb_valid      = (m_pend[r] > 0) || ($urandom_range(0, 15) == 0);
      wb_rd         = wb_valid ? r : 5'($urandom_range(0, 7));
      wb_data       = $urandom;
      r             = 5'($urandom_range(1, 7));
      kill_valid    = ((m_pend[r] > 0) && ($urandom_range(0, 3) == 0)) ||
                      ($urandom_range(0, 31) == 0);
      kill_rd       = r;
      step();
    end

    // Reset mid-operation discards pending state
    issue(5'd6); stall = 1'b0; rs_use = 2'b00; wb_valid = 1'b0; kill_valid = 1'b0;
    mem_fwd_valid = 1'b0;
    step();
    no_issue();
    rst = 1'b0;
    #1;
    chk("mid_rst_sb_err", 64'(sb_err), 64'd0);
    step();
    rst = 1'b1;
    rs_addr = {5'd0, 5'd6}; rs_use = 2'b01;
    #1 chk("mid_rst_hazard", 64'(hazard), 64'd0);
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/id_operand_scoreboard.md
Name: id_operand_scoreboard

Overview:
Parametrised successor to the ID-stage operand path. It combines the architectural register file, MEM/WB operand forwarding for NRP read ports, and a per-register pending-write scoreboard that generates the ID stall. Per-register outstanding-write counters replace the fixed two-source forwarding mux, so issue is safe with multiple in-flight writers, killed instructions, and AXI stalls. It sits between the IF/ID register and the ID/EX register; its hazard output feeds the hazard unit.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers; register 0 is hardwired zero
AW, $clog2(NREG), register index width
NRP, 2, number of read ports
CNTW, 2, per-register pending counter width; at most 2^CNTW-1 outstanding writes per register

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
rs_addr  input  NRP*AW  read indices; port p uses slice [p*AW +: AW]
rs_use  input  NRP  port p operand is actually consumed by the ID instruction
rs_data  output  NRP*XLEN  forwarded operand per port
fwd_sel  output  NRP*2  per port: 0 = regfile, 1 = WB, 2 = MEM, 3 = zero (x0)
issue_valid  input  1  ID holds a valid instruction
issue_wen  input  1  that instruction writes rd
issue_rd  input  AW  destination index
stall  input  1  AXI/memory stall; freezes issue
issue_ready  output  1  instruction may advance this cycle
hazard  output  1  operand not yet available (RAW stall request)
mem_fwd_valid  input  1  MEM stage holds a forwardable (non-load) result
mem_rd  input  AW  MEM destination
mem_data  input  XLEN  MEM ALU result
wb_valid  input  1  WB RegWrite; retires one pending write
wb_rd  input  AW  WB destination
wb_data  input  XLEN  WB data
kill_valid  input  1  a write-enabled instruction past ID was flushed
kill_rd  input  AW  its destination
sb_err  output  1  sticky: a counter was decremented at zero

Behaviour:
- Reset (rst=0, async): all registers set to 0, all pend counters set to 0, sb_err=0. Outputs follow combinationally: issue_ready = !stall, hazard = 0.
- Regfile write: on posedge, if wb_valid && wb_rd != 0, then reg[wb_rd] <= wb_data. Register 0 is never written.
- Read/forward path, combinational, evaluated per port in this priority order:
  - rs == 0: data 0, sel 3.
  - mem_fwd_valid && mem_rd == rs: mem_data, sel 2.
  - wb_valid && wb_rd == rs: wb_data, sel 1.
  - otherwise: reg[rs], sel 0.
  - A same-cycle WB write is therefore always visible; there is no read-old-value window.
- Hazard, per port:
  - mem_hit = mem_fwd_valid && mem_rd == rs; wb_hit = wb_valid && wb_rd == rs.
  - haz_p = rs_use[p] && rs != 0 && pend[rs] > (mem_hit + wb_hit).
  - hazard = OR of haz_p over all ports.
- Saturation: sat = issue_wen && issue_rd != 0 && pend[issue_rd] == 2^CNTW-1.
- issue_ready = !stall && !hazard && !sat. issue_ready is independent of issue_valid.
- Issue fire: fire = issue_valid && issue_ready.
- Counter update, per register r, all on one posedge:
  - inc = fire && issue_wen && issue_rd == r && r != 0.
  - dec = (wb_valid && wb_rd == r) + (kill_valid && kill_rd == r), range 0..2, r != 0.
  - pend[r] <= pend[r] + inc - dec.
  - If dec > pend[r] + inc: clamp to 0 and set sb_err. sb_err clears only on reset.
- Simultaneous inc and dec on the same register: the net value is applied; no priority between sources.
- stall=1: no counter increments. WB and kill decrements still apply, and the regfile write still applies.
- Reset asserted mid-operation: all in-flight pending state is discarded. The pipeline is flushed by the same reset.
- Index >= NREG (non-power-of-two NREG): reads return 0, writes/inc/dec are ignored.
- Timing: zero-latency combinational read/forward path; one-cycle scoreboard update.

Test Plan:
- Reset then read: rst low→high, rs_addr={5,0}, rs_use=11 -> rs_data={0,0}, fwd_sel={0,3}, hazard=0, issue_ready=1.
- RAW stall until WB:
  - Cycle 0: issue rd=5 (wen). Cycle 1: ID reads rs1=5 with no forwards -> hazard=1, issue_ready=0.
  - Then wb_valid, wb_rd=5, wb_data=0xDEADBEEF -> same cycle rs_data=0xDEADBEEF, sel=1, hazard=0. Next cycle pend[5]=0 and regfile reads 0xDEADBEEF.
- MEM priority: pend[7]=2; mem_fwd_valid, mem_rd=7, mem_data=0x11; wb_valid, wb_rd=7, wb_data=0x22 -> rs_data=0x11, sel=2, hazard=0.
- Kill and double decrement: pend[3]=2; same cycle wb_rd=3 and kill_rd=3 -> pend[3]=0, sb_err=0. Repeat kill_rd=3 -> pend[3]=0, sb_err=1.
- Saturation (CNTW=2): three issues to rd=9 with no WB -> fourth issue sees issue_ready=0. One wb_rd=9 -> issue_ready=1 next cycle.
- Stall/x0: stall=1 with issue_valid and rd=4 -> pend[4] unchanged. Issue rd=0 -> no counter change, and rs=0 reads 0 even with wb_rd=0, wb_data=0xFFFFFFFF.
